// File: rtl/coin_start_sequencer.sv
// Turns Start 1P / Start 2P requests into a frame-paced coin-then-select sequence
// for the arcade core. Frame ticks come from rising edges of the core's vblank.
module coin_start_sequencer #(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 8,
  parameter int START_FRAMES = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic       vblank,
  input  logic       start1_req,
  input  logic       start2_req,
  output logic       coin_out,
  output logic [1:0] start_out,
  output logic       busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COIN     = 3'd1;
  localparam logic [2:0] S_COIN_GAP = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_END_GAP  = 3'd4;

  localparam logic [3:0] COIN_LEN  = 4'(COIN_FRAMES);
  localparam logic [3:0] GAP_LEN   = 4'(GAP_FRAMES);
  localparam logic [3:0] START_LEN = 4'(START_FRAMES);

  logic [2:0] state, state_next;
  logic [3:0] fcnt, fcnt_next;
  logic [1:0] coins_left, coins_next;
  logic       sel, sel_next;
  logic       prev1, prev2, prev_vb;

  logic edge1, edge2, tick, frame_done;

  assign edge1      = start1_req & ~prev1;
  assign edge2      = start2_req & ~prev2;
  assign tick       = vblank & ~prev_vb;
  assign frame_done = tick && (fcnt == 4'd1);

  // Every transition reloads fcnt, so a tick landing on the entry edge is never counted.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    coins_next = coins_left;
    sel_next   = sel;
    if (!enable) begin
      state_next = S_IDLE;
      fcnt_next  = 4'd0;
      coins_next = 2'd0;
    end else begin
      if (state != S_IDLE && tick) fcnt_next = fcnt - 4'd1;
      case (state)
        S_IDLE: begin
          if (edge2) begin
            sel_next   = 1'b1;
            coins_next = 2'd2;
            state_next = S_COIN;
            fcnt_next  = COIN_LEN;
          end else if (edge1) begin
            sel_next   = 1'b0;
            coins_next = 2'd1;
            state_next = S_COIN;
            fcnt_next  = COIN_LEN;
          end
        end
        S_COIN: begin
          if (frame_done) begin
            coins_next = coins_left - 2'd1;
            state_next = S_COIN_GAP;
            fcnt_next  = GAP_LEN;
          end
        end
        S_COIN_GAP: begin
          if (frame_done) begin
            if (coins_left != 2'd0) begin
              state_next = S_COIN;
              fcnt_next  = COIN_LEN;
            end else begin
              state_next = S_START;
              fcnt_next  = START_LEN;
            end
          end
        end
        S_START: begin
          if (frame_done) begin
            state_next = S_END_GAP;
            fcnt_next  = GAP_LEN;
          end
        end
        S_END_GAP: begin
          if (frame_done) begin
            state_next = S_IDLE;
            fcnt_next  = 4'd0;
          end
        end
        default: begin
          state_next = S_IDLE;
          fcnt_next  = 4'd0;
        end
      endcase
    end
  end

  // prev registers start at 1 so a button held through reset is not seen as a new press.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      fcnt       <= 4'd0;
      coins_left <= 2'd0;
      sel        <= 1'b0;
      prev1      <= 1'b1;
      prev2      <= 1'b1;
      prev_vb    <= 1'b0;
      coin_out   <= 1'b0;
      start_out  <= 2'b00;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      fcnt       <= fcnt_next;
      coins_left <= coins_next;
      sel        <= sel_next;
      prev1      <= start1_req;
      prev2      <= start2_req;
      prev_vb    <= vblank;
      // Outputs follow the current state one cycle later; a disable blanks them immediately.
      coin_out   <= enable && (state == S_COIN);
      start_out  <= (enable && (state == S_START)) ? (sel ? 2'b10 : 2'b01) : 2'b00;
      busy       <= enable && (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_coin_start_sequencer.sv
// Bench for coin_start_sequencer: a phase-list reference model checked every cycle,
// directed game scenarios with hand-computed pulse lengths, then randomized stimulus.
module tb_coin_start_sequencer;

  logic       clk_sys = 1'b0;
  logic       reset, enable, vblank, start1_req, start2_req;
  logic       coin_out;
  logic [1:0] start_out;
  logic       busy;

  always #5 clk_sys = ~clk_sys;

  coin_start_sequencer #(
    .COIN_FRAMES(2),
    .GAP_FRAMES(3),
    .START_FRAMES(2)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .enable    (enable),
    .vblank    (vblank),
    .start1_req(start1_req),
    .start2_req(start2_req),
    .coin_out  (coin_out),
    .start_out (start_out),
    .busy      (busy)
  );

  localparam int COIN_T  = 2;
  localparam int GAP_T   = 3;
  localparam int START_T = 2;

  int checks = 0;
  int errors = 0;
  int printed = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: a game is a list of phases {coin,start[1:0]} each lasting a number of ticks.
  int         ph_ticks[$];
  logic [2:0] ph_out[$];
  int         rem;
  logic       m_prev1, m_prev2, m_prev_vb;
  logic [3:0] exp_vec = 4'b0;   // {busy, coin, start[1:0]}
  logic       model_valid = 1'b0;

  task automatic load_game(input int players);
    for (int i = 0; i < players; i++) begin
      ph_out.push_back(3'b100); ph_ticks.push_back(COIN_T);
      ph_out.push_back(3'b000); ph_ticks.push_back(GAP_T);
    end
    ph_out.push_back(players == 2 ? 3'b010 : 3'b001); ph_ticks.push_back(START_T);
    ph_out.push_back(3'b000); ph_ticks.push_back(GAP_T);
    rem = ph_ticks[0];
  endtask

  always @(posedge clk_sys) begin
    logic tk, e1, e2, active;
    if (reset) begin
      ph_ticks.delete();
      ph_out.delete();
      m_prev1     = 1'b1;
      m_prev2     = 1'b1;
      m_prev_vb   = 1'b0;
      exp_vec     = 4'b0;
      model_valid = 1'b1;
    end else begin
      active  = (ph_ticks.size() != 0);
      exp_vec = (enable && active) ? {1'b1, ph_out[0]} : 4'b0;
      tk = vblank & ~m_prev_vb;
      e1 = start1_req & ~m_prev1;
      e2 = start2_req & ~m_prev2;
      if (!enable) begin
        ph_ticks.delete();
        ph_out.delete();
      end else if (!active) begin
        if (e2) load_game(2);
        else if (e1) load_game(1);
      end else if (tk) begin
        rem--;
        if (rem == 0) begin
          void'(ph_ticks.pop_front());
          void'(ph_out.pop_front());
          if (ph_ticks.size() != 0) rem = ph_ticks[0];
        end
      end
      m_prev1   = start1_req;
      m_prev2   = start2_req;
      m_prev_vb = vblank;
    end
  end

  // Per-cycle compare plus scenario counters.
  int   coin_rises, coin_cycles, start01_cycles, start10_cycles, busy_cycles;
  logic last_coin = 1'b0;

  always @(negedge clk_sys) begin
    if (model_valid) begin
      checks++;
      if ({busy, coin_out, start_out} !== exp_vec) begin
        errors++;
        if (printed < 20) begin
          printed++;
          $display("FAIL cycle_compare time=%0t actual=%b required=%b",
                   $time, {busy, coin_out, start_out}, exp_vec);
        end
      end
      if (coin_out === 1'b1 && last_coin !== 1'b1) coin_rises++;
      if (coin_out === 1'b1) coin_cycles++;
      if (start_out === 2'b01) start01_cycles++;
      if (start_out === 2'b10) start10_cycles++;
      if (busy === 1'b1) busy_cycles++;
      last_coin = coin_out;
    end
  end

  task automatic clear_mon();
    coin_rises = 0; coin_cycles = 0; start01_cycles = 0; start10_cycles = 0; busy_cycles = 0;
  endtask

  // Driver: inputs change 2 time units after each rising edge.
  int vb_cnt = 0;
  bit vb_rand = 1'b0;

  task automatic next_cycle();
    @(posedge clk_sys); #2;
    vb_cnt = (vb_cnt + 1) % 100;
    vblank = vb_rand ? ($urandom_range(0, 5) == 0) : (vb_cnt < 10);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) next_cycle();
  endtask

  // Leaves the driver in a cycle whose vblank is a rising edge (a tick cycle).
  task automatic align_to_tick();
    while ((vb_cnt + 1) % 100 != 0) next_cycle();
    next_cycle();
  endtask

  // Request on a tick cycle: each frame then lasts exactly 100 clocks.
  task automatic run_game(input string name, input logic s1, input logic s2,
                          input int coins, input int c01, input int c10);
    clear_mon();
    align_to_tick();
    start1_req = s1;
    start2_req = s2;
    wait_cycles(5);
    start1_req = 1'b0;
    start2_req = 1'b0;
    wait_cycles(1700);
    check({name, "_coin_pulses"}, coin_rises, coins);
    check({name, "_coin_cycles"}, coin_cycles, 200 * coins);
    check({name, "_start01_cycles"}, start01_cycles, c01);
    check({name, "_start10_cycles"}, start10_cycles, c10);
    check({name, "_busy_cycles"}, busy_cycles, 500 * coins + 500);
    check({name, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; vblank = 1'b0;
    start1_req = 1'b1; start2_req = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_coin", int'(coin_out), 0);
    check("reset_start", int'(start_out), 0);
    check("reset_busy", int'(busy), 0);

    next_cycle();
    reset = 1'b0;
    clear_mon();
    wait_cycles(300);
    check("held_through_reset_busy", busy_cycles, 0);
    start1_req = 1'b0;
    wait_cycles(5);

    // Request cycle is also a tick cycle, so that tick must not shorten the coin pulse.
    run_game("p1", 1'b1, 1'b0, 1, 200, 0);
    run_game("p2", 1'b0, 1'b1, 2, 0, 200);
    run_game("both", 1'b1, 1'b1, 2, 0, 200);

    clear_mon();
    align_to_tick();
    start1_req = 1'b1;
    wait_cycles(5);
    start1_req = 1'b0;
    wait_cycles(295);
    start2_req = 1'b1;
    wait_cycles(1400);
    start2_req = 1'b0;
    wait_cycles(10);
    check("discard_coin_pulses", coin_rises, 1);
    check("discard_start01", start01_cycles, 200);
    check("discard_start10", start10_cycles, 0);
    check("discard_busy_cycles", busy_cycles, 1000);

    clear_mon();
    align_to_tick();
    start1_req = 1'b1;
    wait_cycles(50);
    check("abort_pre_coin", int'(coin_out), 1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("abort_reset_coin", int'(coin_out), 0);
    check("abort_reset_start", int'(start_out), 0);
    check("abort_reset_busy", int'(busy), 0);
    next_cycle();
    reset = 1'b0;
    clear_mon();
    wait_cycles(1200);
    check("abort_reset_no_restart", busy_cycles + coin_rises, 0);
    start1_req = 1'b0;
    wait_cycles(5);

    clear_mon();
    align_to_tick();
    start1_req = 1'b1;
    wait_cycles(600);
    check("abort_pre_start", int'(start_out), 1);
    enable = 1'b0;
    @(posedge clk_sys); #1;
    check("abort_enable_coin", int'(coin_out), 0);
    check("abort_enable_start", int'(start_out), 0);
    check("abort_enable_busy", int'(busy), 0);
    wait_cycles(20);
    enable = 1'b1;
    clear_mon();
    wait_cycles(1200);
    check("abort_enable_no_restart", busy_cycles + coin_rises, 0);
    start1_req = 1'b0;
    wait_cycles(5);

    vb_rand = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      next_cycle();
      reset = ($urandom_range(0, 2999) == 0);
      if (!start1_req && !start2_req && $urandom_range(0, 399) == 0) begin
        start1_req = 1'b1;
        start2_req = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) start1_req = ~start1_req;
      if ($urandom_range(0, 149) == 0) start2_req = ~start2_req;
      if (enable && $urandom_range(0, 599) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
    end
    reset = 1'b0;
    enable = 1'b1;
    wait_cycles(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
